regwr_scoreboard: RTL and testbench
===================================

# regwr_scoreboard

Parametrised register-file write-enable decoder with an integrated pending-write scoreboard for the CPU datapath. It replaces the fixed 5-to-32 combinational write decoder. It registers a one-hot write strobe from the writeback address and tracks which destination registers have issued but not yet written back. Issue logic uses it to stall on RAW/WAW hazards, and the register file uses its strobe as per-register write enables.

## Interface
- AW, 5, register address width; NR = 2**AW registers
- ZERO_REG, 1, when 1, register 0 is hardwired: never strobed, never busy, never stalls
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- we  input  1  writeback valid
- waddr  input  AW  writeback destination register
- iss_valid  input  1  instruction presented for issue
- iss_addr  input  AW  destination register of issuing instruction
- rs1_addr  input  AW  source register 1 of issuing instruction
- rs2_addr  input  AW  source register 2 of issuing instruction
- stall  output  1  combinational; issue must not be accepted this cycle
- decoderout  output  NR  registered one-hot write strobe to register file
- busy  output  NR  registered scoreboard, bit i = write to reg i pending
- pending  output  AW+1  registered count of set busy bits
- err  output  1  sticky: writeback to a non-busy register observed

## Operation
- Reset is one clock, synchronous, active-high. While rst is high at an edge: decoderout=0, busy=0, pending=0, err=0; we/iss_valid in that cycle are ignored.
- Hazard bit for address a: h(a) = busy[a], forced 0 when ZERO_REG=1 and a=0.
- stall = iss_valid & (h(rs1_addr) | h(rs2_addr) | h(iss_addr)).
- stall is 0 whenever iss_valid=0.
- Accept = iss_valid & ~stall.
- On accept, busy[iss_addr] is set at the next edge. With ZERO_REG=1 and iss_addr=0, nothing is set.
- On we, decoderout is set to (1 << waddr) for exactly one cycle at the next edge. busy[waddr] is cleared at the same edge. All other cycles, decoderout=0.
- With ZERO_REG=1 and waddr=0, decoderout stays 0, busy is untouched, and err is unaffected.
- Writeback error: when we=1 and busy[waddr]=0 (excluding the zero-reg case), err is set at the next edge and stays set until rst. The strobe is still produced.
- Simultaneous accept and writeback to different registers: both take effect at the same edge.
- Simultaneous accept and writeback to the same register X: only possible when busy[X]=0. Set wins, so busy[X]=1 afterwards. err is set and the strobe for X is produced.
- pending = popcount of next-state busy, registered in the same edge as busy, so it always equals popcount(busy).
- No bypass: a writeback in cycle T does not clear stall until T+1.

## Timing
- Latency from we to decoderout: 1 cycle. The strobe is a single-cycle pulse per we cycle. Back-to-back we cycles give back-to-back strobes.
- Latency from we or accept to busy/pending: 1 cycle.
- stall is combinational from busy and the current-cycle addresses. There is no registered stage on the issue path.
- At most one writeback and one issue per cycle. pending stays within 0..NR (0..NR-1 when ZERO_REG=1).
- Reset mid-operation clears all outstanding busy bits. Writebacks arriving after reset for those registers set err.

## Test plan
- Reset, then hold idle 3 cycles -> decoderout=0, busy=0, pending=0, err=0, stall=0 throughout.
- Issue iss_addr=5 (rs1=1, rs2=2) in cycle T; in T+1 present iss_valid with rs1=5 -> busy=0x20 and pending=1 in T+1, stall=1. Writeback waddr=5 in T+3 -> decoderout=0x20 in T+4 only, busy=0, stall=0 in T+4.
- Same cycle: accept issue to reg 7 and writeback to busy reg 3 -> next cycle busy[7]=1, busy[3]=0, decoderout=0x08, pending unchanged, err=0.
- ZERO_REG=1: issue iss_addr=0, rs1=0, then we waddr=0 -> stall=0, busy stays 0, decoderout stays 0, err=0.
- Writeback waddr=9 with busy[9]=0 -> decoderout=0x200 for one cycle, err=1 and stays 1 until rst. Assert rst for one cycle -> err=0.
- AW=3 build: fill registers 1..7 via 7 accepted issues -> pending=7, busy=0xFE. Then an issue with iss_addr=4 -> stall=1. Drain with 7 writebacks -> pending=0, and each strobe is one-hot matching its waddr.

Source files
------------

// File: rtl/regwr_scoreboard_if.sv
// rtl/regwr_scoreboard_if.sv - writeback/issue bundle between datapath and the write scoreboard
interface regwr_scoreboard_if #(
  parameter int AW = 5
);
  localparam int NR = 1 << AW;

  logic          we;
  logic [AW-1:0] waddr;
  logic          iss_valid;
  logic [AW-1:0] iss_addr;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          stall;
  logic [NR-1:0] decoderout;
  logic [NR-1:0] busy;
  logic [AW:0]   pending;
  logic          err;

  modport master (
    output we, waddr, iss_valid, iss_addr, rs1_addr, rs2_addr,
    input  stall, decoderout, busy, pending, err
  );

  modport slave (
    input  we, waddr, iss_valid, iss_addr, rs1_addr, rs2_addr,
    output stall, decoderout, busy, pending, err
  );
endinterface

// File: rtl/regwr_scoreboard.sv
// rtl/regwr_scoreboard.sv - registered one-hot write strobe plus pending-write hazard scoreboard
module regwr_scoreboard #(
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  regwr_scoreboard_if.slave  bus
);
  localparam int NR = 1 << AW;

  logic [NR-1:0] r_busy;
  logic [NR-1:0] r_dec;
  logic [AW:0]   r_pending;
  logic          r_err;

  logic          w_h_rs1;
  logic          w_h_rs2;
  logic          w_h_iss;
  logic          w_stall;
  logic          w_accept;
  logic          w_wb_live;
  logic [NR-1:0] w_set;
  logic [NR-1:0] w_clr;
  logic [NR-1:0] w_busy_nxt;
  logic [AW:0]   w_cnt;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  always_comb begin
    w_h_rs1   = r_busy[bus.rs1_addr] & ~is_zero_reg(bus.rs1_addr);
    w_h_rs2   = r_busy[bus.rs2_addr] & ~is_zero_reg(bus.rs2_addr);
    w_h_iss   = r_busy[bus.iss_addr] & ~is_zero_reg(bus.iss_addr);
    w_stall   = bus.iss_valid & (w_h_rs1 | w_h_rs2 | w_h_iss);
    w_accept  = bus.iss_valid & ~w_stall;
    w_wb_live = bus.we & ~is_zero_reg(bus.waddr);

    w_set = '0;
    w_clr = '0;
    if (w_accept && !is_zero_reg(bus.iss_addr)) w_set[bus.iss_addr] = 1'b1;
    if (w_wb_live) w_clr[bus.waddr] = 1'b1;

    // Set is applied after clear so an issue wins over a same-cycle writeback
    w_busy_nxt = (r_busy & ~w_clr) | w_set;

    w_cnt = '0;
    for (int i = 0; i < NR; i++) begin
      w_cnt = w_cnt + {{AW{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_dec     <= '0;
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_dec     <= w_clr;
      r_pending <= w_cnt;
      if (w_wb_live && !r_busy[bus.waddr]) r_err <= 1'b1;
    end
  end

  assign bus.stall      = w_stall;
  assign bus.decoderout = r_dec;
  assign bus.busy       = r_busy;
  assign bus.pending    = r_pending;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_regwr_scoreboard.sv
// tb/tb_regwr_scoreboard.sv - scoreboard bench for regwr_scoreboard (AW=5/ZERO_REG=1 and AW=3/ZERO_REG=0)
module tb_regwr_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  regwr_scoreboard_if #(.AW(5)) ifa ();
  regwr_scoreboard_if #(.AW(3)) ifb ();

  regwr_scoreboard #(.AW(5), .ZERO_REG(1'b1)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  regwr_scoreboard #(.AW(3), .ZERO_REG(1'b0)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  typedef struct {
    logic [31:0] dec;
    logic [31:0] busy;
    int          pend;
    bit          err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  int aw[2] = '{5, 3};
  bit zr[2] = '{1'b1, 1'b0};
  bit m_busy[2][32];
  bit m_err[2];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d at %0t: got 0x%0h expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  task automatic apply(input int k, input bit we, input int wa, input bit iv,
                       input int ia, input int r1, input int r2);
    if (k == 0) begin
      ifa.we = we; ifa.waddr = wa[4:0]; ifa.iss_valid = iv;
      ifa.iss_addr = ia[4:0]; ifa.rs1_addr = r1[4:0]; ifa.rs2_addr = r2[4:0];
    end else begin
      ifb.we = we; ifb.waddr = wa[2:0]; ifb.iss_valid = iv;
      ifb.iss_addr = ia[2:0]; ifb.rs1_addr = r1[2:0]; ifb.rs2_addr = r2[2:0];
    end
  endtask

  function automatic logic [31:0] get_stall(input int k);
    return (k == 0) ? {31'b0, ifa.stall} : {31'b0, ifb.stall};
  endfunction

  function automatic bit hz(input int k, input int a);
    return m_busy[k][a] && !(zr[k] && a == 0);
  endfunction

  task automatic push_exp(input int k, input logic [31:0] dec);
    exp_t e;
    e.dec  = dec;
    e.busy = '0;
    e.pend = 0;
    for (int i = 0; i < (1 << aw[k]); i++) begin
      if (m_busy[k][i]) begin
        e.busy[i] = 1'b1;
        e.pend++;
      end
    end
    e.err = m_err[k];
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // One clock of stimulus; the model advances from the architectural rules
  task automatic cycle(input int k, input bit we, input int wa, input bit iv,
                       input int ia, input int r1, input int r2);
    bit exp_stall;
    bit live;
    logic [31:0] dec;
    apply(k, we, wa, iv, ia, r1, r2);
    #1;
    exp_stall = iv && (hz(k, r1) || hz(k, r2) || hz(k, ia));
    chk("stall", k, get_stall(k), {31'b0, exp_stall});
    live = we && !(zr[k] && wa == 0);
    dec  = '0;
    if (live) begin
      if (!m_busy[k][wa]) m_err[k] = 1'b1;
      m_busy[k][wa] = 1'b0;
      dec = 32'd1 << wa;
    end
    if (iv && !exp_stall && !(zr[k] && ia == 0)) m_busy[k][ia] = 1'b1;
    push_exp(k, dec);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int k);
    int nr;
    nr = 1 << aw[k];
    apply(k, 1'b1, $urandom_range(0, nr - 1), 1'b1, $urandom_range(0, nr - 1), 0, 0);
    if (k == 0) rst_a = 1'b1;
    else rst_b = 1'b1;
    for (int i = 0; i < 32; i++) m_busy[k][i] = 1'b0;
    m_err[k] = 1'b0;
    push_exp(k, '0);
    @(posedge clk);
    @(negedge clk);
    if (k == 0) rst_a = 1'b0;
    else rst_b = 1'b0;
    apply(k, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic random_run(input int k, input int n);
    int nr;
    int cand[$];
    bit we, iv;
    int wa;
    nr = 1 << aw[k];
    for (int c = 0; c < n; c++) begin
      if (c == n / 2) do_reset(k);
      we = ($urandom_range(0, 1) == 1);
      wa = $urandom_range(0, nr - 1);
      cand.delete();
      for (int i = 0; i < nr; i++) if (m_busy[k][i]) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 3) != 0)
        wa = cand[$urandom_range(0, cand.size() - 1)];
      iv = ($urandom_range(0, 9) < 6);
      cycle(k, we, wa, iv, $urandom_range(0, nr - 1),
            $urandom_range(0, nr - 1), $urandom_range(0, nr - 1));
    end
  endtask

  // Monitor: every clocked output state is matched against the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("decoderout", 0, ifa.decoderout, e.dec);
      chk("busy", 0, ifa.busy, e.busy);
      chk("pending", 0, {26'b0, ifa.pending}, e.pend);
      chk("err", 0, {31'b0, ifa.err}, {31'b0, e.err});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("decoderout", 1, {24'b0, ifb.decoderout}, e.dec);
      chk("busy", 1, {24'b0, ifb.busy}, e.busy);
      chk("pending", 1, {28'b0, ifb.pending}, e.pend);
      chk("err", 1, {31'b0, ifb.err}, {31'b0, e.err});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1);
  end

  initial begin
    apply(0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0);

    // Width-5 instance with hardwired register 0
    do_reset(0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 5, 1, 2);
    cycle(0, 0, 0, 1, 10, 5, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 5, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 12, 5, 5);
    cycle(0, 0, 0, 1, 3, 0, 0);
    cycle(0, 1, 3, 1, 7, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 9, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 11, 1, 11, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    do_reset(0);
    cycle(0, 1, 7, 0, 0, 0, 0);
    cycle(0, 1, 8, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    do_reset(0);
    random_run(0, 300);

    // Width-3 instance where register 0 is an ordinary register
    do_reset(1);
    for (int r = 1; r < 8; r++) cycle(1, 0, 0, 1, r, 0, 0);
    cycle(1, 0, 0, 1, 4, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 1, 0, 0);
    for (int r = 7; r >= 0; r--) cycle(1, 1, r, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    random_run(1, 300);

    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("queue0_drained", 0, q0.size(), 0);
    chk("queue1_drained", 1, q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
